// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM state encoding and sizing helpers for the multi-bank SPI SRAM model.
package spi_ram_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;

  localparam int NUM_BANKS_DEFAULT = 4;

  // Never returns zero so a single-bank build still has a legal index width.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BANK_W = bank_w(NUM_BANKS_DEFAULT);

endpackage

// File: rtl/spi_ram_multibank_edge_sync.sv
// Synchronises the SPI pins into the clk domain and flags spi_clk rise/fall.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int NSEL        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_clk,
  input  logic            spi_mosi,
  input  logic [NSEL-1:0] spi_select,
  output logic            sclk_rise,
  output logic            sclk_fall,
  output logic            mosi,
  output logic [NSEL-1:0] select
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [NSEL-1:0]        sel_q [SYNC_STAGES];
  logic                   clk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q    <= '0;
      mosi_q   <= '0;
      clk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sel_q[i] <= '0;
    end else begin
      clk_q[0]  <= spi_clk;
      mosi_q[0] <= spi_mosi;
      sel_q[0]  <= spi_select;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_q[i]  <= clk_q[i-1];
        mosi_q[i] <= mosi_q[i-1];
        sel_q[i]  <= sel_q[i-1];
      end
      clk_prev <= clk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = clk_q[SYNC_STAGES-1] & ~clk_prev;
  assign sclk_fall = ~clk_q[SYNC_STAGES-1] & clk_prev;
  assign mosi      = mosi_q[SYNC_STAGES-1];
  assign select    = sel_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_ram_multibank.sv
// SPI mode-0 SRAM slave serving NUM_BANKS images behind one bus, with a combinational backdoor read.
// Opcode 0x0B (fast read with 8 dummy bits) is accepted only when SPI_RAM_FAST_READ_EN is defined.
module spi_ram_multibank
  import spi_ram_pkg::*;
#(
  parameter int    NUM_BANKS   = NUM_BANKS_DEFAULT,
  parameter int    BANK_BYTES  = 4096,
  parameter int    ADDR_BITS   = 24,
  parameter int    SYNC_STAGES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  input  logic [NUM_BANKS-1:0]          spi_select,
  output logic                          spi_miso,
  output logic [bank_w(NUM_BANKS)-1:0]  active_bank,
  output logic                          sel_err,
  input  logic [bank_w(NUM_BANKS)-1:0]  debug_bank,
  input  logic [ADDR_BITS-1:0]          debug_addr,
  output logic [31:0]                   debug_data
);

  localparam int BW = bank_w(NUM_BANKS);
  localparam int AW = $clog2(BANK_BYTES);
  localparam int MW = $clog2(NUM_BANKS * BANK_BYTES);
  localparam int CW = $clog2((ADDR_BITS > 8) ? ADDR_BITS : 8);

  logic [7:0] mem [0:NUM_BANKS*BANK_BYTES-1];

  initial begin
    for (int i = 0; i < NUM_BANKS * BANK_BYTES; i++) mem[i] = 8'h00;
  end

  function automatic logic [MW-1:0] midx(input logic [BW-1:0] b, input logic [AW-1:0] a);
    return MW'(int'(b) * BANK_BYTES + int'(a));
  endfunction

  function automatic logic [AW-1:0] addr_add(input logic [AW-1:0] a, input int k);
    return AW'((int'(a) + k) % BANK_BYTES);
  endfunction

  function automatic logic [AW-1:0] wrap_addr(input logic [ADDR_BITS-1:0] a);
    logic [63:0] w;
    w = 64'(a);
    return AW'(w % 64'(BANK_BYTES));
  endfunction

  logic                 sclk_rise, sclk_fall, mosi_s;
  logic [NUM_BANKS-1:0] sel_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .NSEL(NUM_BANKS)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_select(spi_select),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi      (mosi_s),
    .select    (sel_s)
  );

  state_t               state;
  logic [BW-1:0]        bank;
  logic [AW-1:0]        addr;
  logic [ADDR_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic [7:0]           rd_sh;
  logic [7:0]           opcode;
  logic                 multi_hold;
  logic                 wr_vld;
  logic [MW-1:0]        wr_idx;
  logic [7:0]           wr_dat;

  logic                 multi;
  logic [BW-1:0]        sel_idx;
  logic [ADDR_BITS-1:0] shift_in;
  logic [AW-1:0]        addr_in;
  logic [AW-1:0]        addr_nxt;

  assign multi    = $countones(sel_s) > 1;
  assign shift_in = {shreg[ADDR_BITS-2:0], mosi_s};
  assign addr_in  = wrap_addr(shift_in);
  assign addr_nxt = addr_add(addr, 1);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_BANKS; i++) if (sel_s[i]) sel_idx = BW'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank       <= '0;
      addr       <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      rd_sh      <= '0;
      opcode     <= '0;
      spi_miso   <= 1'b0;
      sel_err    <= 1'b0;
      multi_hold <= 1'b0;
      wr_vld     <= 1'b0;
      wr_idx     <= '0;
      wr_dat     <= '0;
    end else begin
      wr_vld <= 1'b0;
      if (multi) begin
        state      <= IGNORE;
        sel_err    <= 1'b1;
        multi_hold <= 1'b1;
        spi_miso   <= 1'b0;
        bit_cnt    <= '0;
      // After a multi-select only a full release re-arms; otherwise losing our own select ends the transaction.
      end else if (state != IDLE && (multi_hold ? (sel_s == '0) : !sel_s[bank])) begin
        state      <= IDLE;
        multi_hold <= 1'b0;
        spi_miso   <= 1'b0;
        bit_cnt    <= '0;
      end else begin
        case (state)
          IDLE: if (sel_s != '0) begin
            bank    <= sel_idx;
            bit_cnt <= '0;
            state   <= CMD;
          end
          CMD: if (sclk_rise) begin
            shreg <= shift_in;
            if (bit_cnt == CW'(7)) begin
              bit_cnt <= '0;
              opcode  <= shift_in[7:0];
              if (shift_in[7:0] == OP_READ || shift_in[7:0] == OP_WRITE) state <= ADDR;
`ifdef SPI_RAM_FAST_READ_EN
              else if (shift_in[7:0] == OP_FAST_READ) state <= ADDR;
`endif
              else state <= IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ADDR: if (sclk_rise) begin
            shreg <= shift_in;
            if (bit_cnt == CW'(ADDR_BITS - 1)) begin
              bit_cnt <= '0;
              addr    <= addr_in;
              if (opcode == OP_WRITE) state <= WRITE;
`ifdef SPI_RAM_FAST_READ_EN
              else if (opcode == OP_FAST_READ) state <= DUMMY;
`endif
              else begin
                state <= READ;
                rd_sh <= mem[midx(bank, addr_in)];
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          DUMMY: if (sclk_rise) begin
            if (bit_cnt == CW'(7)) begin
              bit_cnt <= '0;
              state   <= READ;
              rd_sh   <= mem[midx(bank, addr)];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          READ: if (sclk_fall) begin
            spi_miso <= rd_sh[7];
            if (bit_cnt == CW'(7)) begin
              bit_cnt <= '0;
              addr    <= addr_nxt;
              rd_sh   <= mem[midx(bank, addr_nxt)];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              rd_sh   <= {rd_sh[6:0], 1'b0};
            end
          end
          WRITE: if (sclk_rise) begin
            shreg <= shift_in;
            if (bit_cnt == CW'(7)) begin
              bit_cnt <= '0;
              wr_vld  <= 1'b1;
              wr_idx  <= midx(bank, addr);
              wr_dat  <= shift_in[7:0];
              addr    <= addr_nxt;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_idx] <= wr_dat;
  end

  assign active_bank = bank;

  logic [AW-1:0] dbg_base;
  assign dbg_base = wrap_addr(debug_addr);

  always_comb begin
    debug_data = '0;
    for (int i = 0; i < 4; i++)
      debug_data[8*(3-i) +: 8] = mem[midx(debug_bank, addr_add(dbg_base, i))];
  end

endmodule

// File: tb/tb_spi_ram_multibank.sv
// Directed SPI master driving the multi-bank RAM; expectations queue up ahead of each observation.
module tb_spi_ram_multibank;
  import spi_ram_pkg::*;

  localparam int HALF = 4;

  logic              clk, rst_n, spi_clk, spi_mosi, spi_miso, sel_err;
  logic [3:0]        spi_select;
  logic [BANK_W-1:0] active_bank, debug_bank;
  logic [23:0]       debug_addr;
  logic [31:0]       debug_data;

  spi_ram_multibank dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_select(spi_select), .spi_miso(spi_miso), .active_bank(active_bank),
    .sel_err(sel_err), .debug_bank(debug_bank), .debug_addr(debug_addr),
    .debug_data(debug_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [31:0] mask;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;
  exp_t        cur_e;
  logic [31:0] cur_o;

  always @(posedge clk) begin
    while (obs_q.size() > 0) begin
      cur_o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_obs got %h with no expectation", cur_o);
      end else begin
        cur_e = exp_q.pop_front();
        if ((cur_o & cur_e.mask) !== (cur_e.val & cur_e.mask)) begin
          errors++;
          $display("FAIL %s got %h expected %h (mask %h)", cur_e.name, cur_o, cur_e.val, cur_e.mask);
        end
      end
    end
  end

  task automatic expect_v(input string n, input logic [31:0] v, input logic [31:0] m);
    exp_t e;
    e.name = n; e.val = v; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      rx[i] = spi_miso;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic start(input int b, input logic [7:0] op, input logic [23:0] a);
    logic [7:0] r;
    spi_select = 4'(1 << b);
    repeat (HALF) @(negedge clk);
    expect_v("active_bank", 32'(b), 32'hFFFF_FFFF);
    observe(32'(active_bank));
    xfer(op, 8, r);
    xfer(a[23:16], 8, r);
    xfer(a[15:8], 8, r);
    xfer(a[7:0], 8, r);
  endtask

  task automatic stop();
    repeat (HALF) @(negedge clk);
    spi_select = 4'b0000;
    spi_mosi   = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    logic [7:0] r;
    xfer(d, 8, r);
  endtask

  task automatic rd(input string n, input logic [7:0] e);
    logic [7:0] r;
    expect_v(n, {24'h0, e}, 32'h0000_00FF);
    xfer(8'h00, 8, r);
    observe({24'h0, r});
  endtask

  task automatic dbg(input string n, input int b, input logic [23:0] a,
                     input logic [31:0] e, input logic [31:0] m);
    debug_bank = BANK_W'(b);
    debug_addr = a;
    expect_v(n, e, m);
    #1;
    observe(debug_data);
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [31:0] v, input logic [31:0] e);
    expect_v(n, e, 32'hFFFF_FFFF);
    observe(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    rst_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_select = 4'b0000;
    debug_bank = '0; debug_addr = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(spi_miso), 32'h0);
    chk("rst_active_bank", 32'(active_bank), 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Distinct backgrounds in every bank, then overwrite the start of bank 2.
    start(0, OP_WRITE, 24'h10); wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04); stop();
    start(1, OP_WRITE, 24'h10); wr(8'h11); wr(8'h12); wr(8'h13); wr(8'h14); stop();
    start(3, OP_WRITE, 24'h10); wr(8'h31); wr(8'h32); wr(8'h33); wr(8'h34); stop();
    start(2, OP_WRITE, 24'h10); wr(8'h21); wr(8'h22); wr(8'h23); wr(8'h24); stop();
    start(2, OP_WRITE, 24'h10); wr(8'hDE); wr(8'hAD); stop();
    dbg("bank2_dead", 2, 24'h10, 32'hDEAD2324, 32'hFFFF_FFFF);
    dbg("bank0_kept", 0, 24'h10, 32'h01020304, 32'hFFFF_FFFF);
    dbg("bank1_kept", 1, 24'h10, 32'h11121314, 32'hFFFF_FFFF);
    dbg("bank3_kept", 3, 24'h10, 32'h31323334, 32'hFFFF_FFFF);

    // Write across the top of bank 0 so the address wraps to 0x000.
    start(0, OP_WRITE, 24'hFFE); wr(8'h9B); wr(8'h9C); wr(8'h11); wr(8'h22); wr(8'h33); stop();
    start(0, OP_WRITE, 24'h005); wr(8'h5A); stop();
    dbg("dbg_wrap", 0, 24'hFFE, 32'h9B9C1122, 32'hFFFF_FFFF);
    dbg("dbg_alias", 0, 24'h001FFF, 32'h9C112233, 32'hFFFF_FFFF);

    start(0, OP_READ, 24'h0); rd("rd0_b0", 8'h11); rd("rd0_b1", 8'h22); rd("rd0_b2", 8'h33); stop();
    start(0, OP_READ, 24'hFFF); rd("rd_top", 8'h9C); rd("rd_wrap", 8'h11); stop();
    start(0, OP_READ, 24'h001005); rd("rd_alias", 8'h5A); stop();

    // Half a byte then deselect: the byte must be dropped and the next opcode decoded fresh.
    start(0, OP_WRITE, 24'h20); wr(8'h77); stop();
    start(0, OP_WRITE, 24'h20); xfer(8'hF0, 4, r); stop();
    dbg("partial_dropped", 0, 24'h20, 32'h7700_0000, 32'hFF00_0000);
    start(0, OP_READ, 24'h20); rd("rd_after_partial", 8'h77); stop();

    spi_select = 4'b0011;
    repeat (HALF) @(negedge clk);
    chk("sel_err_set", 32'(sel_err), 32'h1);
    foreach (r[i]) r[i] = 1'b0;
    expect_v("multi_miso_op", 32'h0, 32'hFF); xfer(OP_WRITE, 8, r); observe({24'h0, r});
    expect_v("multi_miso_a2", 32'h0, 32'hFF); xfer(8'h00, 8, r); observe({24'h0, r});
    expect_v("multi_miso_a1", 32'h0, 32'hFF); xfer(8'h00, 8, r); observe({24'h0, r});
    expect_v("multi_miso_a0", 32'h0, 32'hFF); xfer(8'h20, 8, r); observe({24'h0, r});
    expect_v("multi_miso_d",  32'h0, 32'hFF); xfer(8'h55, 8, r); observe({24'h0, r});
    stop();
    chk("sel_err_sticky", 32'(sel_err), 32'h1);
    dbg("multi_no_write", 0, 24'h20, 32'h7700_0000, 32'hFF00_0000);
    start(1, OP_READ, 24'h10); rd("rd_after_multi", 8'h11); stop();
    chk("sel_err_still", 32'(sel_err), 32'h1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("sel_err_cleared", 32'(sel_err), 32'h0);
    chk("bank_cleared", 32'(active_bank), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    dbg("mem_persists", 0, 24'h0, 32'h1122335A & 32'hFFFF_FF00, 32'hFFFF_FF00);

    start(0, OP_FAST_READ, 24'h0);
    rd("fast_dummy", 8'h00);
`ifdef SPI_RAM_FAST_READ_EN
    rd("fast_data", 8'h11);
`else
    rd("fast_data", 8'h00);
`endif
    stop();

    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing observation, expected %h", cur_e.name, cur_e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
